// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequencing controller for a restoring binary divider that
// shares one external (WIDTH+1)-bit adder. Holds partial remainder R,
// quotient shift register Q, divisor D and a bit counter. Each quotient bit
// costs two cycles (SHIFT then SUB); a CHECK cycle up front short-circuits
// divide-by-zero.
// Optional build macro: DIV_BUSY_ERR_EN adds a sticky 'err' output that
// flags start requests arriving while an operation is in flight.
module div_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH:0]   add_a,
  output logic [WIDTH:0]   add_b,
  output logic             add_cin,
  input  logic             add_cout,
  input  logic [WIDTH:0]   add_sum
`ifdef DIV_BUSY_ERR_EN
  ,
  output logic             err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_SHIFT = 3'd2,
    S_SUB   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             busy_s;
  logic             accept_s;
  logic [WIDTH-1:0] q_new_s;
  logic [WIDTH:0]   r_new_s;

  assign busy_s   = (state_q == S_CHECK) || (state_q == S_SHIFT) || (state_q == S_SUB);
  assign accept_s = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  assign busy      = busy_s;
  assign done      = (state_q == S_DONE);
  assign dbz       = dbz_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

  // Next-state, datapath update and shared-adder operand decode
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    add_a   = {(WIDTH + 1){1'b0}};
    add_b   = {(WIDTH + 1){1'b0}};
    add_cin = 1'b0;
    q_new_s = q_q;
    r_new_s = r_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          q_d     = dividend;
          d_d     = divisor;
          r_d     = {(WIDTH + 1){1'b0}};
          cnt_d   = CNT_W'(WIDTH);
          dbz_d   = 1'b0;
          state_d = S_CHECK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        if (d_q == {WIDTH{1'b0}}) begin
          // Q still holds the captured dividend at this point
          quo_d   = {WIDTH{1'b1}};
          rem_d   = q_q;
          dbz_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {r_d, q_d} = {r_q[WIDTH-1:0], q_q, 1'b0};
        state_d    = S_SHIFT;
        state_d    = S_SUB;
      end
      S_SUB: begin
        // R - D computed as R + ~D + 1; carry-out set means R >= D
        add_a   = r_q;
        add_b   = ~{1'b0, d_q};
        add_cin = 1'b1;
        if (add_cout) begin
          r_new_s = add_sum;
          q_new_s = {q_q[WIDTH-1:1], 1'b1};
        end else begin
          r_new_s = r_q;
          q_new_s = {q_q[WIDTH-1:1], 1'b0};
        end
        r_d   = r_new_s;
        q_d   = q_new_s;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          quo_d   = q_new_s;
          rem_d   = r_new_s[WIDTH-1:0];
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= {(WIDTH + 1){1'b0}};
      q_q     <= {WIDTH{1'b0}};
      d_q     <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      dbz_q   <= 1'b0;
      quo_q   <= {WIDTH{1'b0}};
      rem_q   <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

`ifdef DIV_BUSY_ERR_EN
  logic err_q, err_d;

  // Sticky busy-violation flag, cleared by the next accepted start
  always_comb begin
    err_d = err_q;
    if (accept_s) begin
      err_d = 1'b0;
    end else if (start && busy_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Busy-violation flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Sequencing controller for a restoring binary divider that time-shares one external adder.
- Holds the partial remainder, quotient and bit counter.
- Drives the adder operands each iteration and decides restore or keep from the adder carry-out.
- Sits between the divider top level and the shared adder instance; gives an unsigned WIDTH-bit quotient and remainder over a start/busy/done handshake.

Parameters:
- WIDTH, 8: operand, quotient and remainder width in bits; must be at least 2.
- CNT_W, $clog2(WIDTH+1): width of the internal bit counter.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- dividend  in  WIDTH  numerator; captured on the accepted start.
- divisor  in  WIDTH  denominator; captured on the accepted start.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle completion pulse.
- dbz  out  1  divide-by-zero flag; valid while done=1 and held until the next accepted start.
- quotient  out  WIDTH  result; held until the next accepted start.
- remainder  out  WIDTH  result; held until the next accepted start.
- add_a  out  WIDTH+1  shared-adder operand A.
- add_b  out  WIDTH+1  shared-adder operand B.
- add_cin  out  1  shared-adder carry-in.
- add_cout  in  1  shared-adder carry-out.
- add_sum  in  WIDTH+1  shared-adder sum.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; busy, done, dbz = 0; quotient, remainder, internal R/Q/D/count = 0. Takes effect immediately, including mid-operation. The aborted operation produces no done pulse.
- Internal registers: R is WIDTH+1 bits (partial remainder), Q is WIDTH bits, D is WIDTH bits, count is CNT_W bits.
- States:
  - IDLE: busy=0.
  - CHECK, SHIFT, SUB: busy=1.
  - DONE: busy=0, done=1 for exactly one cycle.
- IDLE or DONE, start=1: capture Q=dividend, D=divisor, R=0, count=WIDTH, dbz=0; go to CHECK. Otherwise DONE returns to IDLE.
- CHECK:
  - If D==0: quotient=all ones, remainder=dividend, dbz=1; go to DONE.
  - Else go to SHIFT.
- SHIFT: {R,Q} shifted left by 1 (R takes Q MSB; Q[0]=0); go to SUB.
- SUB:
  - Adder drives add_a=R, add_b=~{1'b0,D}, add_cin=1.
  - add_cout=1 (R>=D): R=add_sum, Q[0]=1.
  - add_cout=0: R unchanged, Q[0]=0.
  - count decrements. If count becomes 0: quotient=Q (with the new bit), remainder=R[WIDTH-1:0]; go to DONE. Else go to SHIFT.
- Adder operands:
  - Combinational from registers.
  - Valid only in SUB; add_a, add_b, add_cin = 0 in every other state.
  - add_sum and add_cout are consumed only in SUB.
- Latency, counting the start-sampling edge as edge 1:
  - Normal operation: done rises after edge 2*WIDTH+2 (2 cycles per bit plus CHECK).
  - dbz case: done rises after edge 2.
- start while busy=1: ignored, no side effects.
- start in the DONE cycle: accepted. done still pulses that cycle, then CHECK follows.
- Back-to-back operations are therefore supported with no idle gap.
- dividend and divisor are don't-care except on the accepting edge.

Optional Feature:
- Macro: DIV_BUSY_ERR_EN.
- Defined:
  - Adds output port err (1 bit, reset 0).
  - err sets sticky when start=1 is sampled while busy=1.
  - err clears on the next accepted start.
  - err has no effect on the computation.
- Undefined: the err port and its logic are absent; start while busy is silently ignored.

Test Plan (WIDTH=8, external adder model add_sum/add_cout = add_a+add_b+add_cin):
- dividend=100, divisor=7, start 1 cycle -> busy 16+1 cycles; done after edge 18; quotient=14, remainder=2, dbz=0.
- 255/1 -> quotient=255, remainder=0. Then 5/9 issued in the DONE cycle -> quotient=0, remainder=5, done 18 edges after that start.
- 37/0 -> done after edge 2, dbz=1, quotient=255, remainder=37; add_a, add_b, add_cin stay 0 throughout.
- 200/3 started, start pulsed again with 10/2 at edge 6 -> result 66 r 2, second request dropped. With DIV_BUSY_ERR_EN: err=1 from edge 6, cleared by the next accepted start.
- 100/7 started, rst_n=0 asynchronously at edge 9 -> all outputs 0 immediately, no done pulse. After release, 9/4 -> quotient=2, remainder=1.
- Sweep all 256x255 non-zero-divisor pairs -> quotient and remainder match the reference model; add_b is non-zero only in SUB cycles.
